// File: rtl/zpu_pkg.sv
// Shared types and constants for the ZPU memory path.
package zpu_pkg;

   localparam int MEM_AW  = 20;
   localparam int BYTE_AW = 22;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      WR     = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4,
      DONE   = 3'd5
   } mem_state_t;

endpackage

// File: rtl/mem_access_lane_mux.sv
// lane_mux: big-endian lane extraction (zero-extended) and lane merge.
// Offset 0 is the most significant lane of the word.
module lane_mux
   import zpu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [15:0] i_data,
   input  logic [1:0]  i_off,
   input  mem_size_t   i_size,
   output logic [31:0] o_extract,
   output logic [31:0] o_merge
);

   // Select the addressed lane for loads and splice store data into it for RMW.
   always_comb begin
      o_extract = i_word;
      o_merge   = i_word;
      case (i_size)
         SIZE_BYTE: begin
            case (i_off)
               2'd0: begin o_extract = {24'd0, i_word[31:24]}; o_merge[31:24] = i_data[7:0]; end
               2'd1: begin o_extract = {24'd0, i_word[23:16]}; o_merge[23:16] = i_data[7:0]; end
               2'd2: begin o_extract = {24'd0, i_word[15:8]};  o_merge[15:8]  = i_data[7:0]; end
               default: begin o_extract = {24'd0, i_word[7:0]}; o_merge[7:0] = i_data[7:0]; end
            endcase
         end
         SIZE_HALF: begin
            if (i_off[1] == 1'b0) begin
               o_extract      = {16'd0, i_word[31:16]};
               o_merge[31:16] = i_data;
            end else begin
               o_extract      = {16'd0, i_word[15:0]};
               o_merge[15:0]  = i_data;
            end
         end
         default: begin
            o_extract = i_word;
            o_merge   = i_word;
         end
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// mem_access: byte-addressed load/store unit in front of the 1M x 32 RAM.
// Sub-word stores use read-modify-write. Define ALIGN_CHECK_EN to fault
// misaligned requests instead of force-aligning them.
module mem_access
   import zpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [BYTE_AW-1:0] i_addr,
   input  logic [1:0]         i_size,
   input  logic               i_read,
   input  logic               i_write,
   input  logic [31:0]        i_data,
   output logic [31:0]        o_data,
   output logic               o_done,
   output logic               o_busy,
   output logic               o_error,
   output logic [MEM_AW-1:0]  o_mem_addr,
   output logic               o_mem_read,
   output logic               o_mem_write,
   output logic [31:0]        o_mem_data,
   input  logic [31:0]        i_mem_data,
   input  logic               i_mem_done
);

   mem_state_t        r_state,     w_state_nxt;
   logic [MEM_AW-1:0] r_mem_addr,  w_mem_addr_nxt;
   logic [1:0]        r_off,       w_off_nxt;
   mem_size_t         r_size,      w_size_nxt;
   logic [15:0]       r_wdata,     w_wdata_nxt;
   logic [31:0]       r_data,      w_data_nxt;
   logic [31:0]       r_mem_data,  w_mem_data_nxt;
   logic              r_done,      w_done_nxt;
   logic              r_busy,      w_busy_nxt;
   logic              r_error,     w_error_nxt;
   logic              r_mem_read,  w_mem_read_nxt;
   logic              r_mem_write, w_mem_write_nxt;

   mem_size_t   w_req_size;
   logic [1:0]  w_req_off;
   logic        w_misalign;
   logic        w_accept;
   logic [31:0] w_extract;
   logic [31:0] w_merge;

   lane_mux u_lane_mux (
      .i_word    (i_mem_data),
      .i_data    (r_wdata),
      .i_off     (r_off),
      .i_size    (r_size),
      .o_extract (w_extract),
      .o_merge   (w_merge)
   );

   // Decode the incoming request: effective size, aligned offset, fault flag.
   always_comb begin
      case (i_size)
         2'd0: begin w_req_size = SIZE_BYTE; w_req_off = i_addr[1:0]; end
         2'd1: begin w_req_size = SIZE_HALF; w_req_off = {i_addr[1], 1'b0}; end
         default: begin w_req_size = SIZE_WORD; w_req_off = 2'b00; end
      endcase
`ifdef ALIGN_CHECK_EN
      case (i_size)
         2'd0:    w_misalign = 1'b0;
         2'd1:    w_misalign = i_addr[0];
         2'd2:    w_misalign = |i_addr[1:0];
         default: w_misalign = 1'b1;
      endcase
`else
      w_misalign = 1'b0;
`endif
   end

   // Next-state and next-output logic; strobes and o_done are single-cycle.
   always_comb begin
      w_state_nxt     = r_state;
      w_mem_addr_nxt  = r_mem_addr;
      w_off_nxt       = r_off;
      w_size_nxt      = r_size;
      w_wdata_nxt     = r_wdata;
      w_data_nxt      = r_data;
      w_mem_data_nxt  = r_mem_data;
      w_done_nxt      = 1'b0;
      w_error_nxt     = 1'b0;
      w_mem_read_nxt  = 1'b0;
      w_mem_write_nxt = 1'b0;
      w_accept        = 1'b0;

      case (r_state)
         IDLE, DONE: begin
            w_accept    = i_read | i_write;
            w_state_nxt = IDLE;
            if (w_accept) begin
               w_mem_addr_nxt = i_addr[BYTE_AW-1:2];
               w_off_nxt      = w_req_off;
               w_size_nxt     = w_req_size;
               w_wdata_nxt    = i_data[15:0];
               if (w_misalign) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
                  w_error_nxt = 1'b1;
               end else if (i_write) begin
                  if (w_req_size == SIZE_WORD) begin
                     w_state_nxt     = WR;
                     w_mem_write_nxt = 1'b1;
                     w_mem_data_nxt  = i_data;
                  end else begin
                     w_state_nxt    = RMW_RD;
                     w_mem_read_nxt = 1'b1;
                  end
               end else begin
                  w_state_nxt    = RD;
                  w_mem_read_nxt = 1'b1;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RD: begin
            if (i_mem_done) begin
               w_data_nxt  = w_extract;
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = RD;
            end
         end
         RMW_RD: begin
            if (i_mem_done) begin
               w_mem_data_nxt  = w_merge;
               w_mem_write_nxt = 1'b1;
               w_state_nxt     = RMW_WR;
            end else begin
               w_state_nxt = RMW_RD;
            end
         end
         WR, RMW_WR: begin
            if (i_mem_done) begin
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = r_state;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == RD) || (w_state_nxt == WR) ||
                   (w_state_nxt == RMW_RD) || (w_state_nxt == RMW_WR);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_mem_addr  <= {MEM_AW{1'b0}};
         r_off       <= 2'b00;
         r_size      <= SIZE_BYTE;
         r_wdata     <= 16'd0;
         r_data      <= 32'd0;
         r_mem_data  <= 32'd0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_error     <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_off       <= w_off_nxt;
         r_size      <= w_size_nxt;
         r_wdata     <= w_wdata_nxt;
         r_data      <= w_data_nxt;
         r_mem_data  <= w_mem_data_nxt;
         r_done      <= w_done_nxt;
         r_busy      <= w_busy_nxt;
         r_error     <= w_error_nxt;
         r_mem_read  <= w_mem_read_nxt;
         r_mem_write <= w_mem_write_nxt;
      end
   end

   assign o_data      = r_data;
   assign o_done      = r_done;
   assign o_busy      = r_busy;
   assign o_error     = r_error;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_read  = r_mem_read;
   assign o_mem_write = r_mem_write;
   assign o_mem_data  = r_mem_data;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed test-plan steps followed by
// random requests checked against an arithmetic big-endian reference model.
// Expectations follow ALIGN_CHECK_EN the same way the design does.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [21:0] i_addr;
   logic [1:0]  i_size;
   logic        i_read;
   logic        i_write;
   logic [31:0] i_data;
   logic [31:0] o_data;
   logic        o_done;
   logic        o_busy;
   logic        o_error;
   logic [19:0] o_mem_addr;
   logic        o_mem_read;
   logic        o_mem_write;
   logic [31:0] o_mem_data;
   logic [31:0] i_mem_data = 32'd0;
   logic        i_mem_done = 1'b0;

   logic [31:0] ram     [0:63];
   logic [31:0] ref_ram [0:63];
   logic [31:0] last_load;
   int n_rd;
   int n_wr;
   int n_both;
   int compared;
   int mismatched;

   mem_access dut (
      .clk(clk), .reset_n(reset_n), .i_addr(i_addr), .i_size(i_size),
      .i_read(i_read), .i_write(i_write), .i_data(i_data), .o_data(o_data),
      .o_done(o_done), .o_busy(o_busy), .o_error(o_error),
      .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
      .o_mem_data(o_mem_data), .i_mem_data(i_mem_data), .i_mem_done(i_mem_done)
   );

   always #5 clk = ~clk;

   // RAM: samples strobes at the edge, answers with a one-cycle done pulse.
   always @(posedge clk) begin
      i_mem_done <= 1'b0;
      if (o_mem_read && o_mem_write) n_both = n_both + 1;
      if (o_mem_read) begin
         i_mem_data <= ram[o_mem_addr[5:0]];
         i_mem_done <= 1'b1;
         n_rd = n_rd + 1;
      end else if (o_mem_write) begin
         ram[o_mem_addr[5:0]] = o_mem_data;
         i_mem_done <= 1'b1;
         n_wr = n_wr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared = compared + 1;
      assert (obs === exp) else begin
         mismatched = mismatched + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_data"},  o_data, 32'd0);
      chk({tag, "_done"},  32'(o_done), 32'd0);
      chk({tag, "_busy"},  32'(o_busy), 32'd0);
      chk({tag, "_error"}, 32'(o_error), 32'd0);
      chk({tag, "_maddr"}, 32'(o_mem_addr), 32'd0);
      chk({tag, "_mrd"},   32'(o_mem_read), 32'd0);
      chk({tag, "_mwr"},   32'(o_mem_write), 32'd0);
      chk({tag, "_mdata"}, o_mem_data, 32'd0);
   endtask

   // One request: compute the expected outcome, drive it, then check it.
   task automatic run_req(input string tag, input logic rd, input logic wr,
                          input logic [21:0] addr, input logic [1:0] sz,
                          input logic [31:0] dat, input bit poke);
      int widx, esz, nb, eoff, sh, n, exp_lat, exp_rd, exp_wr;
      logic [31:0] msk;
      bit mis;
      widx = int'(addr[7:2]);
      esz  = (sz == 2'd3) ? 2 : int'(sz);
      nb   = 1 << esz;
      eoff = int'(addr[1:0]) & ~(nb - 1);
      mis  = 1'b0;
`ifdef ALIGN_CHECK_EN
      mis  = (sz == 2'd3) || ((int'(addr[1:0]) & (nb - 1)) != 0);
`endif
      sh   = (4 - eoff - nb) * 8;
      msk  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (mis) begin
         exp_lat = 1; exp_rd = 0; exp_wr = 0;
      end else if (wr) begin
         ref_ram[widx] = (ref_ram[widx] & ~(msk << sh)) | ((dat & msk) << sh);
         exp_lat = (nb == 4) ? 3 : 5;
         exp_rd  = (nb == 4) ? 0 : 1;
         exp_wr  = 1;
      end else begin
         last_load = (ref_ram[widx] >> sh) & msk;
         exp_lat = 3; exp_rd = 1; exp_wr = 0;
      end

      @(negedge clk);
      i_read = rd; i_write = wr; i_addr = addr; i_size = sz; i_data = dat;
      n_rd = 0; n_wr = 0;
      @(negedge clk);
      i_read = 1'b0; i_write = 1'b0;
      n = 1;
      if (!mis) chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      if (poke) begin
         i_read = 1'b1;
         i_addr = addr ^ 22'h4;
      end
      while (o_done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n = n + 1;
         i_read = 1'b0;
      end
      i_read = 1'b0;
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_error"},   32'(o_error), 32'(mis));
      chk({tag, "_data"},    o_data, last_load);
      chk({tag, "_rdstb"},   32'(n_rd), 32'(exp_rd));
      chk({tag, "_wrstb"},   32'(n_wr), 32'(exp_wr));
      chk({tag, "_ram"},     ram[widx], ref_ram[widx]);
   endtask

   initial begin
      int seen_done;
      logic [21:0] ra;
      logic rr, rw;
      compared = 0; mismatched = 0;
      n_rd = 0; n_wr = 0; n_both = 0;
      last_load = 32'd0;
      for (int i = 0; i < 64; i++) begin
         ram[i] = $urandom;
         ref_ram[i] = ram[i];
      end
      ram[5] = 32'h1122_3344; ref_ram[5] = 32'h1122_3344;
      ram[8] = 32'h5566_7788; ref_ram[8] = 32'h5566_7788;
      reset_n = 1'b0; i_addr = 22'd0; i_size = 2'd0;
      i_read = 1'b0; i_write = 1'b0; i_data = 32'd0;
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      reset_n = 1'b1;

      run_req("word_ld",   1'b1, 1'b0, 22'h14, 2'd2, 32'd0, 1'b0);
      chk("word_ld_val", o_data, 32'h1122_3344);
      run_req("byte_ld15", 1'b1, 1'b0, 22'h15, 2'd0, 32'd0, 1'b0);
      chk("byte_ld15_val", o_data, 32'h0000_0022);
      run_req("byte_ld17", 1'b1, 1'b0, 22'h17, 2'd0, 32'd0, 1'b0);
      chk("byte_ld17_val", o_data, 32'h0000_0044);
      run_req("byte_st",   1'b0, 1'b1, 22'h16, 2'd0, 32'hFFFF_FFAB, 1'b0);
      chk("byte_st_val", ram[5], 32'h1122_AB44);
      run_req("half_st",   1'b0, 1'b1, 22'h20, 2'd1, 32'h1234_BEEF, 1'b0);
      chk("half_st_val", ram[8], 32'hBEEF_7788);
      run_req("half_ld",   1'b1, 1'b0, 22'h20, 2'd1, 32'd0, 1'b0);
      chk("half_ld_val", o_data, 32'h0000_BEEF);
      run_req("busy_poke", 1'b1, 1'b0, 22'h22, 2'd1, 32'd0, 1'b1);
      run_req("rd_and_wr", 1'b1, 1'b1, 22'h18, 2'd2, 32'hCAFE_F00D, 1'b0);
      chk("rd_and_wr_val", ram[6], 32'hCAFE_F00D);

      // Reset while the RMW read is outstanding; its late done must be ignored.
      @(negedge clk);
      i_write = 1'b1; i_addr = 22'h16; i_size = 2'd0; i_data = 32'h0000_005A;
      n_rd = 0; n_wr = 0;
      @(negedge clk);
      i_write = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      chk_outputs_zero("mid_reset");
      reset_n = 1'b1;
      last_load = 32'd0;
      seen_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (o_done === 1'b1 || o_busy === 1'b1) seen_done = seen_done + 1;
      end
      chk("mid_reset_quiet", 32'(seen_done), 32'd0);
      chk("mid_reset_wrstb", 32'(n_wr), 32'd0);
      chk("mid_reset_ram", ram[5], 32'h1122_AB44);

      run_req("word_ld_odd", 1'b1, 1'b0, 22'h15, 2'd2, 32'd0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         ra = 22'($urandom_range(0, 63));
         rw = 1'($urandom_range(0, 1));
         rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
         run_req("rand", rr, rw, ra, 2'($urandom_range(0, 3)), $urandom, 1'b0);
      end

      chk("strobe_overlap", 32'(n_both), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Byte-addressed load/store unit between the ZPU core and the 1M×32 word RAM. Accepts byte, halfword and word requests on a 22-bit byte address and issues word-wide read/write cycles to the RAM. Sub-word loads are extracted and zero-extended big-endian; sub-word stores use a read-modify-write sequence.

## Interface
- No parameters. Widths are fixed by the 1M-word RAM.
- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- i_addr  in  22  byte address from core; [21:2] word index, [1:0] byte offset
- i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- i_read  in  1  load request, sampled only when idle
- i_write  in  1  store request, sampled only when idle; wins over i_read
- i_data  in  32  store data, right-justified for byte/half
- o_data  out  32  load result, zero-extended, right-justified
- o_done  out  1  one-cycle completion pulse
- o_busy  out  1  high from the cycle after acceptance until o_done
- o_error  out  1  alignment fault, pulses with o_done (ALIGN_CHECK_EN only, else tied 0)
- o_mem_addr  out  20  word address to RAM
- o_mem_read  out  1  RAM read strobe
- o_mem_write  out  1  RAM write strobe
- o_mem_data  out  32  RAM write data
- i_mem_data  in  32  RAM read data, valid when i_mem_done
- i_mem_done  in  1  RAM completion, one cycle after a strobe

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- IDLE: request latched (addr, size, data). Next state is RD for a load, WR for a word store, RMW_RD for a byte/half store. With i_read and i_write both high, the request is treated as a store.
- RD/WR/RMW_RD/RMW_WR: the strobe is registered high for exactly one cycle on entry. The FSM then waits for i_mem_done.
- RD + i_mem_done: extract the lane, load o_data, go to DONE.
- RMW_RD + i_mem_done: merge the latched store data into the word, go to RMW_WR with the merged data on o_mem_data.
- WR/RMW_WR + i_mem_done: go to DONE.
- DONE: o_done = 1 for one cycle, then IDLE. A request can be accepted in the same cycle as o_done.
- Lane mapping is big-endian:
  - Byte offset 0 maps to bits [31:24] and offset 3 to [7:0].
  - Halfword offset 0 maps to [31:16] and offset 2 to [15:0].
- Merge replaces only the addressed lane with i_data[7:0] or i_data[15:0]. The other lanes keep the value read from RAM.
- Any i_mem_done that arrives in IDLE or DONE is ignored.
- Requests seen while o_busy is high are ignored and are not queued.
- Reset values: all outputs 0, state IDLE. Reset mid-operation abandons the transaction. A write strobe already issued still completes in the RAM.

## Timing
- Request sampled at edge E0. Strobe is high in the cycle after E0, RAM samples it at E1.
- i_mem_done is high after E1.
- Load and word store: captured at E2, o_done high in the cycle after E2. Latency is 3 cycles.
- Byte/half store: read strobe after E0, write strobe after E2, o_done after E4. Latency is 5 cycles.
- o_mem_read and o_mem_write are never high in the same cycle.
- o_data holds its value until the next completed load.

## Configuration
- ALIGN_CHECK_EN defined:
  - A half at an odd offset, a word at a nonzero offset, or size 3 gives DONE with o_error = 1 in the cycle after E0.
  - No RAM strobe is issued and o_data is unchanged.
- ALIGN_CHECK_EN undefined:
  - Offset bits below the access size are ignored (forced alignment) and size 3 is treated as a word.
  - o_error is tied 0.

## Structure
- Shared package zpu_pkg holds:
  - mem_size_t enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - mem_state_t enum: the six states above.
  - Constants MEM_AW = 20 and BYTE_AW = 22.
- One combinational sub-module, lane_mux, holds both lane functions:
  - extract: word, offset, size → zero-extended result.
  - merge: word, data, offset, size → merged word.
- lane_mux is instantiated once. The FSM and registers stay in mem_access.

## Test plan
- Word load: RAM[5] = 0x11223344, read addr 0x14 size 2 → o_data = 0x11223344, o_done 3 cycles after the request.
- Byte loads: RAM[5] = 0x11223344, read byte at 0x15 → 0x00000022, at 0x17 → 0x00000044.
- Byte store RMW: RAM[5] = 0x11223344, store 0xAB at 0x16 → RAM[5] = 0x1122AB44, o_done after 5 cycles, exactly one read strobe and one write strobe.
- Half store then load: store 0xBEEF at 0x20 → RAM[8][31:16] = 0xBEEF, [15:0] unchanged; half load at 0x20 → 0x0000BEEF.
- Busy and priority:
  - Assert i_read while o_busy is high → ignored.
  - Assert i_read and i_write together in IDLE → store performed.
  - Pull reset_n low during RMW_RD → next cycle all outputs 0, IDLE; the late i_mem_done is ignored.
- With ALIGN_CHECK_EN: word read at 0x15 → o_error = 1 and o_done = 1 one cycle later, no mem strobe. Without the macro, the same read returns RAM[5].
